// File: rtl/spi_slave_stream.sv
// SPI slave with valid/ready RX and TX streams, oversampled on the system clock.
// Supports all four SPI modes, either bit order, and back-to-back words per frame.
module spi_slave_stream #(
    parameter int              DATA_W    = 8,
    parameter bit              CPOL      = 1'b0,
    parameter bit              CPHA      = 1'b0,
    parameter bit              LSB_FIRST = 1'b0,
    parameter logic [DATA_W-1:0] TX_IDLE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SCK,
    input  logic              SSEL,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_oe,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        sck_sync;
    logic [2:0]        ssel_sync;
    logic [1:0]        mosi_sync;
    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_next;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_buf;
    logic              buf_full;

    logic sck_rise, sck_fall, lead_edge, trail_edge;
    logic sample_edge, shift_edge, ssel_fall, ssel_rise;
    logic active, do_sample, do_shift, word_done, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {3{CPOL}};
            ssel_sync <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], SCK};
            ssel_sync <= {ssel_sync[1:0], SSEL};
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    assign sck_rise    = sck_sync[1] & ~sck_sync[2];
    assign sck_fall    = ~sck_sync[1] & sck_sync[2];
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ssel_fall   = ~ssel_sync[1] & ssel_sync[2];
    assign ssel_rise   = ssel_sync[1] & ~ssel_sync[2];

    assign active    = (state_q == ACTIVE);
    assign do_sample = active && sample_edge && !ssel_rise;
    assign do_shift  = active && shift_edge && !ssel_rise;
    assign word_done = do_sample && (bitcnt == LAST_BIT);
    // CPHA=0 must present the first bit before any SCK edge, so it loads at frame start
    assign load      = (do_shift && (bitcnt == '0)) ||
                       (!CPHA && ssel_fall && (state_q == IDLE));

    assign rx_next = LSB_FIRST ? {mosi_sync[1], rx_shift[DATA_W-1:1]}
                               : {rx_shift[DATA_W-2:0], mosi_sync[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ssel_fall) state_d = ACTIVE;
            ACTIVE:  if (ssel_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Leaving the frame discards any partial word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt   <= '0;
            rx_shift <= '0;
        end else if (!active || ssel_rise) begin
            bitcnt   <= '0;
            rx_shift <= '0;
        end else if (do_sample) begin
            rx_shift <= rx_next;
            bitcnt   <= word_done ? '0 : bitcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (word_done) begin
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end else begin
                    rx_data  <= rx_next;
                    rx_valid <= 1'b1;
                end
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // A write in the same cycle as a load only refills the buffer for the next load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift    <= '0;
            tx_buf      <= '0;
            buf_full    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load) begin
                if (buf_full) begin
                    tx_shift <= tx_buf;
                    buf_full <= 1'b0;
                end else begin
                    tx_shift    <= TX_IDLE;
                    tx_underrun <= 1'b1;
                end
            end else if (do_shift) begin
                tx_shift <= LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
            end
            if (tx_valid && !buf_full) begin
                tx_buf   <= tx_data;
                buf_full <= 1'b1;
            end
        end
    end

    assign tx_ready = !buf_full;
    assign MISO     = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1];
    assign MISO_oe  = active;
    assign busy     = active;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: a mode-0 8-bit MSB-first instance and
// a mode-3 16-bit LSB-first instance driven by a bit-banged SPI master.
module tb_spi_slave_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       SCK0, SSEL0, MOSI0, MISO0, MISO_oe0;
    logic [7:0] rx_data0, tx_data0;
    logic       rx_valid0, rx_ready0, tx_valid0, tx_ready0;
    logic       rx_overrun0, tx_underrun0, busy0;

    logic        SCK3, SSEL3, MOSI3, MISO3, MISO_oe3;
    logic [15:0] rx_data3, tx_data3;
    logic        rx_valid3, rx_ready3, tx_valid3, tx_ready3;
    logic        rx_overrun3, tx_underrun3, busy3;

    spi_slave_stream #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0),
                       .TX_IDLE(8'hFF)) dut0 (
        .clk(clk), .rst_n(rst_n), .SCK(SCK0), .SSEL(SSEL0), .MOSI(MOSI0),
        .MISO(MISO0), .MISO_oe(MISO_oe0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(rx_ready0), .tx_data(tx_data0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .rx_overrun(rx_overrun0), .tx_underrun(tx_underrun0),
        .busy(busy0)
    );

    spi_slave_stream #(.DATA_W(16), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1),
                       .TX_IDLE(16'h0000)) dut3 (
        .clk(clk), .rst_n(rst_n), .SCK(SCK3), .SSEL(SSEL3), .MOSI(MOSI3),
        .MISO(MISO3), .MISO_oe(MISO_oe3), .rx_data(rx_data3), .rx_valid(rx_valid3),
        .rx_ready(rx_ready3), .tx_data(tx_data3), .tx_valid(tx_valid3),
        .tx_ready(tx_ready3), .rx_overrun(rx_overrun3), .tx_underrun(tx_underrun3),
        .busy(busy3)
    );

    int checks = 0;
    int errors = 0;

    int und0 = 0;
    int ovr0 = 0;
    int und3 = 0;
    logic [15:0] rxq3 [$];

    always @(posedge clk) begin
        if (tx_underrun0) und0 <= und0 + 1;
        if (rx_overrun0)  ovr0 <= ovr0 + 1;
        if (tx_underrun3) und3 <= und3 + 1;
        if (rx_valid3 && rx_ready3) rxq3.push_back(rx_data3);
    end

    typedef struct packed {
        logic [7:0] mosi;
        logic [7:0] tx;
        bit         load;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
        int         exp_und;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic writeTx0(input logic [7:0] d);
        @(negedge clk);
        tx_data0  = d;
        tx_valid0 = 1'b1;
        @(negedge clk);
        tx_valid0 = 1'b0;
    endtask

    task automatic writeTx3(input logic [15:0] d);
        @(negedge clk);
        tx_data3  = d;
        tx_valid3 = 1'b1;
        @(negedge clk);
        tx_valid3 = 1'b0;
    endtask

    task automatic consume0();
        @(negedge clk);
        rx_ready0 = 1'b1;
        @(negedge clk);
        rx_ready0 = 1'b0;
        waitClk(1);
    endtask

    // Mode 0 master: word k occupies bits [8k+7:8k], each word sent MSB first
    task automatic xfer0(input logic [23:0] words, input int nbits,
                         output logic [23:0] miso_bits);
        int idx;
        miso_bits = '0;
        SSEL0 = 1'b0;
        waitClk(8);
        checkOutput("busy0_in_frame", 32'(busy0), 32'h1);
        checkOutput("miso_oe0_in_frame", 32'(MISO_oe0), 32'h1);
        for (int k = 0; k < nbits; k++) begin
            idx = (k / 8) * 8 + 7 - (k % 8);
            MOSI0 = words[idx];
            waitClk(8);
            SCK0 = 1'b1;
            miso_bits[idx] = MISO0;
            waitClk(8);
            SCK0 = 1'b0;
        end
        waitClk(8);
        SSEL0 = 1'b1;
        waitClk(8);
    endtask

    // Mode 3 master, LSB first: bit k of the 32-bit vector is the k-th bit on the wire
    task automatic xfer3(input logic [31:0] words, input logic [15:0] refill,
                         output logic [31:0] miso_bits);
        miso_bits = '0;
        SSEL3 = 1'b0;
        waitClk(8);
        for (int k = 0; k < 32; k++) begin
            MOSI3 = words[k];
            SCK3  = 1'b0;
            waitClk(8);
            SCK3  = 1'b1;
            miso_bits[k] = MISO3;
            if (k == 0) begin
                writeTx3(refill);
                waitClk(6);
            end else begin
                waitClk(8);
            end
        end
        SSEL3 = 1'b1;
        waitClk(8);
    endtask

    task automatic applyStimulus(input vec_t v, output logic [7:0] miso_w,
                                 output int und_delta);
        int u0;
        logic [23:0] mb;
        if (v.load) begin
            writeTx0(v.tx);
            checkOutput("tx_ready0_buffer_full", 32'(tx_ready0), 32'h0);
        end
        u0 = und0;
        xfer0({16'h0000, v.mosi}, 8, mb);
        miso_w    = mb[7:0];
        und_delta = und0 - u0;
    endtask

    initial begin
        logic [7:0]  mw;
        logic [23:0] mb;
        logic [31:0] mb3;
        int          ud;
        int          o0;
        int          u3;

        vecs[0] = '{mosi: 8'h3C, tx: 8'hA5, load: 1'b1, exp_rx: 8'h3C, exp_miso: 8'hA5, exp_und: 1};
        vecs[1] = '{mosi: 8'h00, tx: 8'hFF, load: 1'b1, exp_rx: 8'h00, exp_miso: 8'hFF, exp_und: 1};
        vecs[2] = '{mosi: 8'hFF, tx: 8'h00, load: 1'b1, exp_rx: 8'hFF, exp_miso: 8'h00, exp_und: 1};
        vecs[3] = '{mosi: 8'h96, tx: 8'h00, load: 1'b0, exp_rx: 8'h96, exp_miso: 8'hFF, exp_und: 2};
        vecs[4] = '{mosi: 8'h81, tx: 8'h7E, load: 1'b1, exp_rx: 8'h81, exp_miso: 8'h7E, exp_und: 1};

        rst_n = 1'b0;
        SCK0 = 1'b0; SSEL0 = 1'b1; MOSI0 = 1'b0; rx_ready0 = 1'b0;
        tx_valid0 = 1'b0; tx_data0 = '0;
        SCK3 = 1'b1; SSEL3 = 1'b1; MOSI3 = 1'b0; rx_ready3 = 1'b1;
        tx_valid3 = 1'b0; tx_data3 = '0;
        waitClk(4);

        checkOutput("reset_rx_valid0", 32'(rx_valid0), 32'h0);
        checkOutput("reset_rx_data0", 32'(rx_data0), 32'h0);
        checkOutput("reset_tx_ready0", 32'(tx_ready0), 32'h1);
        checkOutput("reset_busy0", 32'(busy0), 32'h0);
        checkOutput("reset_miso_oe0", 32'(MISO_oe0), 32'h0);
        checkOutput("reset_miso0", 32'(MISO0), 32'h0);
        checkOutput("reset_tx_ready3", 32'(tx_ready3), 32'h1);
        checkOutput("reset_rx_valid3", 32'(rx_valid3), 32'h0);
        rst_n = 1'b1;
        waitClk(4);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i], mw, ud);
            checkOutput($sformatf("row%0d_miso", i), 32'(mw), 32'(vecs[i].exp_miso));
            checkOutput($sformatf("row%0d_rx_valid", i), 32'(rx_valid0), 32'h1);
            checkOutput($sformatf("row%0d_rx_data", i), 32'(rx_data0), 32'(vecs[i].exp_rx));
            checkOutput($sformatf("row%0d_underruns", i), 32'(ud), 32'(vecs[i].exp_und));
            checkOutput($sformatf("row%0d_tx_ready", i), 32'(tx_ready0), 32'h1);
            consume0();
            checkOutput($sformatf("row%0d_rx_valid_cleared", i), 32'(rx_valid0), 32'h0);
        end

        // Three words with the consumer stalled
        o0 = ovr0;
        xfer0(24'h332211, 24, mb);
        checkOutput("ovr_count", 32'(ovr0 - o0), 32'h2);
        checkOutput("ovr_rx_data", 32'(rx_data0), 32'h11);
        checkOutput("ovr_rx_valid", 32'(rx_valid0), 32'h1);
        consume0();
        checkOutput("ovr_rx_valid_cleared", 32'(rx_valid0), 32'h0);

        // Frame aborted after five bits, then a clean frame
        o0 = ovr0;
        xfer0(24'h0000FF, 5, mb);
        checkOutput("partial_no_valid", 32'(rx_valid0), 32'h0);
        checkOutput("partial_no_overrun", 32'(ovr0 - o0), 32'h0);
        xfer0(24'h000081, 8, mb);
        checkOutput("after_partial_rx_valid", 32'(rx_valid0), 32'h1);
        checkOutput("after_partial_rx_data", 32'(rx_data0), 32'h81);
        consume0();

        // Mode 3, two words in one frame with a refill between them
        writeTx3(16'hCAFE);
        checkOutput("m3_tx_ready_full", 32'(tx_ready3), 32'h0);
        u3 = und3;
        xfer3({16'hBEEF, 16'h1234}, 16'h5A3C, mb3);
        checkOutput("m3_miso_word0", 32'(mb3[15:0]), 32'hCAFE);
        checkOutput("m3_miso_word1", 32'(mb3[31:16]), 32'h5A3C);
        checkOutput("m3_underruns", 32'(und3 - u3), 32'h0);
        checkOutput("m3_tx_ready_after", 32'(tx_ready3), 32'h1);
        checkOutput("m3_rx_count", 32'(rxq3.size()), 32'h2);
        if (rxq3.size() >= 2) begin
            checkOutput("m3_rx_word0", 32'(rxq3[0]), 32'h1234);
            checkOutput("m3_rx_word1", 32'(rxq3[1]), 32'hBEEF);
        end

        // Asynchronous reset in the middle of a word with rx_valid pending
        xfer0(24'h00005A, 8, mb);
        checkOutput("pre_reset_rx_valid", 32'(rx_valid0), 32'h1);
        SSEL0 = 1'b0;
        waitClk(8);
        writeTx0(8'h55);
        checkOutput("pre_reset_tx_ready", 32'(tx_ready0), 32'h0);
        MOSI0 = 1'b1;
        waitClk(6);
        SCK0 = 1'b1;
        waitClk(8);
        SCK0 = 1'b0;
        waitClk(4);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_rx_valid", 32'(rx_valid0), 32'h0);
        checkOutput("async_rst_rx_data", 32'(rx_data0), 32'h0);
        checkOutput("async_rst_tx_ready", 32'(tx_ready0), 32'h1);
        checkOutput("async_rst_busy", 32'(busy0), 32'h0);
        checkOutput("async_rst_miso_oe", 32'(MISO_oe0), 32'h0);
        checkOutput("async_rst_miso", 32'(MISO0), 32'h0);
        SSEL0 = 1'b1;
        SCK0  = 1'b0;
        waitClk(3);
        rst_n = 1'b1;
        waitClk(4);

        writeTx0(8'h3C);
        xfer0(24'h0000C3, 8, mb);
        checkOutput("post_reset_miso", 32'(mb[7:0]), 32'h3C);
        checkOutput("post_reset_rx_valid", 32'(rx_valid0), 32'h1);
        checkOutput("post_reset_rx_data", 32'(rx_data0), 32'hC3);
        consume0();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
